// File: rtl/cpu6.sv
// cpu6: multi-cycle 8-bit CPU running a reduced Centurion CPU6 subset on a byte-wide memory/IO bus.
// Latency: 1 to 5 cycles per instruction (fetch, 0-2 operand reads, 0-2 exec/data cycles).
// Backpressure: none; memory answers combinationally and accepts one write in any cycle.
module cpu6 (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  data_in,
  output logic        write_en,
  output logic [15:0] address,
  output logic [7:0]  data_out
);

  typedef enum logic [2:0] {
    S_FETCH, S_OP1, S_OP2, S_EXEC, S_MEM1, S_MEM2, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV,
    ALU_CLR, ALU_INV, ALU_SRA, ALU_SLA
  } alu_op_t;

  localparam logic [15:0] RESET_PC = 16'hFD00;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ea_q, ea_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  regs_q [16];
  logic [7:0]  regs_d [16];
  logic        z_q, z_d, n_q, n_d, l_q, l_d, v_q, v_d, ie_q, ie_d, f_q, f_d;

  logic        bus_we;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dat;

  alu_op_t     alu_op;
  logic        alu_wide;
  logic [3:0]  alu_dst;
  logic [15:0] alu_a, alu_b, alu_res;
  logic [16:0] alu_raw;
  logic        alu_c, alu_z, alu_n, alu_v, alu_l, alu_sets_l;
  logic        a_msb, b_msb, r_msb;
  logic        br_taken;

  // Pick EXEC-cycle operands, destination and width from the opcode and operand byte.
  always_comb begin
    alu_op   = ALU_MOV;
    alu_wide = 1'b0;
    alu_dst  = 4'd1;
    alu_a    = 16'h0000;
    alu_b    = 16'h0000;
    case (ir_q[7:4])
      4'h2, 4'h3: begin
        case (ir_q[2:0])
          3'd0:    alu_op = ALU_ADD;
          3'd1:    alu_op = ALU_SUB;
          3'd2:    alu_op = ALU_CLR;
          3'd3:    alu_op = ALU_INV;
          3'd4:    alu_op = ALU_SRA;
          default: alu_op = ALU_SLA;
        endcase
        if (ir_q[4:3] == 2'b00) begin
          // INR/DCR/CLR/IVR: register in the high nibble, step n+1 in the low nibble
          alu_dst = op1_q[7:4];
          alu_a   = {8'h00, regs_q[op1_q[7:4]]};
          alu_b   = {12'h000, op1_q[3:0]} + 16'd1;
        end else if (ir_q[4] == 1'b0) begin
          alu_dst = 4'd1;
          alu_a   = {8'h00, regs_q[1]};
          alu_b   = 16'd1;
        end else begin
          alu_wide = 1'b1;
          alu_dst  = 4'd0;
          alu_a    = {regs_q[0], regs_q[1]};
          alu_b    = 16'd1;
        end
      end
      4'h4, 4'h5: begin
        case (ir_q[2:0])
          3'd0:    alu_op = ALU_ADD;
          3'd1:    alu_op = ALU_SUB;
          3'd2:    alu_op = ALU_AND;
          3'd3:    alu_op = ALU_OR;
          3'd4:    alu_op = ALU_XOR;
          default: alu_op = ALU_MOV;
        endcase
        if (ir_q[4]) begin
          alu_wide = 1'b1;
          alu_dst  = 4'd2;
          alu_a    = {regs_q[2], regs_q[3]};
          alu_b    = {regs_q[0], regs_q[1]};
        end else if (ir_q[3]) begin
          alu_dst = 4'd3;
          alu_a   = {8'h00, regs_q[3]};
          alu_b   = {8'h00, regs_q[1]};
        end else begin
          alu_dst = op1_q[3:0];
          alu_a   = {8'h00, regs_q[op1_q[3:0]]};
          alu_b   = {8'h00, regs_q[op1_q[7:4]]};
        end
      end
      default: ;
    endcase
  end

  // ALU datapath; byte results come from the low 8 bits, so carry sits at bit 8 or bit 16.
  always_comb begin
    alu_raw = 17'h00000;
    case (alu_op)
      ALU_ADD: alu_raw = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: alu_raw = {1'b0, alu_a} - {1'b0, alu_b};
      ALU_AND: alu_raw = {1'b0, alu_a & alu_b};
      ALU_OR:  alu_raw = {1'b0, alu_a | alu_b};
      ALU_XOR: alu_raw = {1'b0, alu_a ^ alu_b};
      ALU_MOV: alu_raw = {1'b0, alu_b};
      ALU_CLR: alu_raw = 17'h00000;
      ALU_INV: alu_raw = {1'b0, ~alu_a};
      ALU_SRA: alu_raw = {2'b00, alu_a[15:1]};
      ALU_SLA: alu_raw = {alu_a, 1'b0};
      default: alu_raw = 17'h00000;
    endcase
    alu_res = alu_wide ? alu_raw[15:0] : {8'h00, alu_raw[7:0]};
    alu_c   = alu_wide ? alu_raw[16] : alu_raw[8];
    a_msb   = alu_wide ? alu_a[15] : alu_a[7];
    b_msb   = alu_wide ? alu_b[15] : alu_b[7];
    r_msb   = alu_wide ? alu_res[15] : alu_res[7];
    alu_z   = (alu_res == 16'h0000);
    alu_n   = r_msb;
    alu_v      = 1'b0;
    alu_l      = l_q;
    alu_sets_l = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_v = (a_msb == b_msb) && (r_msb != a_msb);
        alu_l = alu_c;
        alu_sets_l = 1'b1;
      end
      ALU_SUB: begin
        // L reads as "no borrow" after a subtract
        alu_v = (a_msb != b_msb) && (r_msb != a_msb);
        alu_l = ~alu_c;
        alu_sets_l = 1'b1;
      end
      ALU_SRA: begin
        alu_l = alu_a[0];
        alu_sets_l = 1'b1;
      end
      ALU_SLA: begin
        alu_l = alu_c;
        alu_sets_l = 1'b1;
      end
      default: ;
    endcase
  end

  // Branch condition from the low opcode bits: L, ~L, Z, ~Z, N, ~N.
  always_comb begin
    case (ir_q[2:0])
      3'd0:    br_taken = l_q;
      3'd1:    br_taken = ~l_q;
      3'd4:    br_taken = z_q;
      3'd5:    br_taken = ~z_q;
      3'd6:    br_taken = n_q;
      3'd7:    br_taken = ~n_q;
      default: br_taken = 1'b0;
    endcase
  end

  // Instruction sequencer: next state, architectural updates and bus request.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ea_d    = ea_q;
    ir_d    = ir_q;
    op1_d   = op1_q;
    regs_d  = regs_q;
    z_d = z_q; n_d = n_q; l_d = l_q; v_d = v_q; ie_d = ie_q; f_d = f_q;
    bus_we   = 1'b0;
    bus_addr = pc_q;
    bus_dat  = 8'h00;
    case (state_q)
      S_FETCH: begin
        ir_d = data_in;
        pc_d = pc_q + 16'd1;
        case (data_in)
          8'h00: state_d = S_HALT;
          8'h02: f_d = 1'b1;
          8'h03: f_d = 1'b0;
          8'h04: ie_d = 1'b1;
          8'h05: ie_d = 1'b0;
          8'h06: l_d = 1'b1;
          8'h07: l_d = 1'b0;
          8'h08: l_d = ~l_q;
          8'h10, 8'h11, 8'h14, 8'h15, 8'h16, 8'h17,
          8'h20, 8'h21, 8'h22, 8'h23,
          8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45,
          8'h71, 8'h80, 8'h81, 8'h90, 8'h91, 8'hA1, 8'hB1,
          8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hE1, 8'hF1: state_d = S_OP1;
          8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2C, 8'h2D,
          8'h38, 8'h39, 8'h3A, 8'h3B, 8'h3C, 8'h3D,
          8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C, 8'h4D,
          8'h58, 8'h59, 8'h5A, 8'h5B, 8'h5C, 8'h5D: state_d = S_EXEC;
          default: ;  // undefined opcodes behave as NOP
        endcase
      end
      S_OP1: begin
        op1_d   = data_in;
        pc_d    = pc_q + 16'd1;
        state_d = S_OP2;
        case (ir_q)
          8'h10, 8'h11, 8'h14, 8'h15, 8'h16, 8'h17: begin
            state_d = S_FETCH;
            if (br_taken) pc_d = pc_q + 16'd1 + {{8{data_in[7]}}, data_in};
          end
          8'h20, 8'h21, 8'h22, 8'h23,
          8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45: state_d = S_EXEC;
          8'h80, 8'hC0: begin
            if (ir_q[6]) regs_d[3] = data_in;
            else         regs_d[1] = data_in;
            z_d = (data_in == 8'h00);
            n_d = data_in[7];
            v_d = 1'b0;
            state_d = S_FETCH;
          end
          default: ;
        endcase
      end
      S_OP2: begin
        pc_d    = pc_q + 16'd1;
        ea_d    = {op1_q, data_in};
        state_d = S_MEM1;
        case (ir_q)
          8'h71: begin
            pc_d    = {op1_q, data_in};
            state_d = S_FETCH;
          end
          8'h90, 8'hD0: begin
            if (ir_q[6]) begin regs_d[2] = op1_q; regs_d[3] = data_in; end
            else         begin regs_d[0] = op1_q; regs_d[1] = data_in; end
            z_d = ({op1_q, data_in} == 16'h0000);
            n_d = op1_q[7];
            v_d = 1'b0;
            state_d = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM1: begin
        bus_addr = ea_q;
        state_d  = S_FETCH;
        case (ir_q)
          8'h81, 8'hC1: begin
            if (ir_q[6]) regs_d[3] = data_in;
            else         regs_d[1] = data_in;
            z_d = (data_in == 8'h00);
            n_d = data_in[7];
            v_d = 1'b0;
          end
          8'h91, 8'hD1: begin
            op1_d   = data_in;  // high byte held until the low byte arrives
            state_d = S_MEM2;
          end
          8'hA1: begin bus_we = 1'b1; bus_dat = regs_q[1]; end
          8'hE1: begin bus_we = 1'b1; bus_dat = regs_q[3]; end
          8'hB1: begin bus_we = 1'b1; bus_dat = regs_q[0]; state_d = S_MEM2; end
          8'hF1: begin bus_we = 1'b1; bus_dat = regs_q[2]; state_d = S_MEM2; end
          default: ;
        endcase
      end
      S_MEM2: begin
        bus_addr = ea_q + 16'd1;
        state_d  = S_FETCH;
        case (ir_q)
          8'h91, 8'hD1: begin
            if (ir_q[6]) begin regs_d[2] = op1_q; regs_d[3] = data_in; end
            else         begin regs_d[0] = op1_q; regs_d[1] = data_in; end
            z_d = ({op1_q, data_in} == 16'h0000);
            n_d = op1_q[7];
            v_d = 1'b0;
          end
          8'hB1: begin bus_we = 1'b1; bus_dat = regs_q[1]; end
          8'hF1: begin bus_we = 1'b1; bus_dat = regs_q[3]; end
          default: ;
        endcase
      end
      S_EXEC: begin
        if (alu_wide) begin
          regs_d[alu_dst]         = alu_res[15:8];
          regs_d[alu_dst | 4'd1]  = alu_res[7:0];
        end else begin
          regs_d[alu_dst] = alu_res[7:0];
        end
        z_d = alu_z;
        n_d = alu_n;
        v_d = alu_v;
        if (alu_sets_l) l_d = alu_l;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Reset overrides the bus in the same cycle so an in-flight store never lands.
  assign write_en = reset ? 1'b0 : bus_we;
  assign address  = reset ? RESET_PC : bus_addr;
  assign data_out = reset ? 8'h00 : bus_dat;

  // Architectural state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ea_q    <= 16'h0000;
      ir_q    <= 8'h00;
      op1_q   <= 8'h00;
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
      z_q <= 1'b0; n_q <= 1'b0; l_q <= 1'b0; v_q <= 1'b0; ie_q <= 1'b0; f_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ea_q    <= ea_d;
      ir_q    <= ir_d;
      op1_q   <= op1_d;
      regs_q  <= regs_d;
      z_q <= z_d; n_q <= n_d; l_q <= l_d; v_q <= v_d; ie_q <= ie_d; f_q <= f_d;
    end
  end

endmodule

// File: tb/tb_cpu6.sv
// tb_cpu6: directed program run against a behavioural memory with a write log.
// Latency: checks are cycle-exact around reset, fetch sequence, stores and halt.
// Backpressure: none; memory answers reads combinationally and captures every write.
module tb_cpu6;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        write_en;
  logic [15:0] address;
  logic [7:0]  data_out;

  logic [7:0]  mem [0:65535];
  logic [15:0] wa [0:63];
  logic [7:0]  wd [0:63];
  int          wc [0:63];
  int          wr_cnt = 0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  prog [$];

  cpu6 dut (
    .clock    (clock),
    .reset    (reset),
    .data_in  (data_in),
    .write_en (write_en),
    .address  (address),
    .data_out (data_out)
  );

  always #5 clock = ~clock;

  assign data_in = mem[address];

  // Memory write port plus a log of every write with its cycle number.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (write_en) begin
      mem[address]    <= data_out;
      wa[wr_cnt[5:0]] <= address;
      wd[wr_cnt[5:0]] <= data_out;
      wc[wr_cnt[5:0]] <= cyc;
      wr_cnt          <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input int n, input int budget);
    int g;
    g = 0;
    while (wr_cnt < n && g < budget) begin
      @(negedge clock);
      g++;
    end
    chk("write_arrived", (wr_cnt >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic chk_wr(input int i, input logic [15:0] a, input logic [7:0] d);
    chk("wr_addr", {16'h0, wa[i]}, {16'h0, a});
    chk("wr_data", {24'h0, wd[i]}, {24'h0, d});
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFD00] = 8'h71; mem[16'hFD01] = 8'h80; mem[16'hFD02] = 8'h01;
    prog = '{8'h80, 8'h48, 8'hA1, 8'hF2, 8'h01,           // LDAL 48; STAL F201
             8'h80, 8'h03, 8'h21, 8'h10, 8'h15, 8'hFC,    // LDAL 03; loop DCR AL / BNZ -4
             8'hA1, 8'hB0, 8'h00,                         // STAL B000
             8'h80, 8'hFF, 8'hC0, 8'h01, 8'h48,           // AL=FF BL=01 ADD
             8'hE1, 8'hB0, 8'h01,                         // STBL B001
             8'h80, 8'h7F, 8'hC0, 8'h01, 8'h48,           // AL=7F BL=01 ADD
             8'hE1, 8'hB0, 8'h02,                         // STBL B002
             8'h90, 8'h12, 8'h34, 8'hB1, 8'hB8, 8'h00,    // LDAW 1234; STAW B800
             8'h90, 8'h80, 8'h01, 8'h3D,                  // LDAW 8001; SLAW
             8'hB1, 8'hB0, 8'h04,                         // STAW B004
             8'h41, 8'h13, 8'hE1, 8'hB0, 8'h06,           // SUB BL-=AL; STBL B006
             8'h80, 8'h01, 8'hA1, 8'hF9, 8'h00,           // LDAL 01; STAL F900
             8'h00};                                      // HLT
    foreach (prog[i]) mem[16'h8001 + i] = prog[i];

    // Reset held four cycles
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("rst_we", {31'h0, write_en}, 32'd0);
    chk("rst_addr", {16'h0, address}, 32'hFD00);
    chk("rst_dout", {24'h0, data_out}, 32'd0);
    chk("rst_flag_l", {31'h0, dut.l_q}, 32'd0);
    chk("rst_al", {24'h0, dut.regs_q[1]}, 32'd0);
    reset = 1'b0;
    #1;
    chk("fetch0_addr", {16'h0, address}, 32'hFD00);
    @(negedge clock);
    chk("fetch1_addr", {16'h0, address}, 32'hFD01);
    chk("fetch1_we", {31'h0, write_en}, 32'd0);
    @(negedge clock);
    chk("fetch2_addr", {16'h0, address}, 32'hFD02);
    chk("fetch2_we", {31'h0, write_en}, 32'd0);
    @(negedge clock);
    chk("jmp_target", {16'h0, address}, 32'h8001);
    chk("jmp_no_write", wr_cnt, 32'd0);

    // UART byte
    wait_wr(1, 100);
    chk_wr(0, 16'hF201, 8'h48);
    chk("uart_z", {31'h0, dut.z_q}, 32'd0);
    chk("uart_n", {31'h0, dut.n_q}, 32'd0);

    // Counted loop: 2 + 3*(3+2) + 4 cycles from one store to the next
    wait_wr(2, 200);
    chk_wr(1, 16'hB000, 8'h00);
    chk("loop_cycles", wc[1] - wc[0], 32'd21);
    chk("loop_z", {31'h0, dut.z_q}, 32'd1);

    // FF + 01 -> 00 with carry
    wait_wr(3, 100);
    chk_wr(2, 16'hB001, 8'h00);
    chk("add1_z", {31'h0, dut.z_q}, 32'd1);
    chk("add1_l", {31'h0, dut.l_q}, 32'd1);
    chk("add1_v", {31'h0, dut.v_q}, 32'd0);

    // 7F + 01 -> 80 signed overflow
    wait_wr(4, 100);
    chk_wr(3, 16'hB002, 8'h80);
    chk("add2_n", {31'h0, dut.n_q}, 32'd1);
    chk("add2_v", {31'h0, dut.v_q}, 32'd1);
    chk("add2_l", {31'h0, dut.l_q}, 32'd0);

    // Word store, big-endian, back-to-back cycles
    wait_wr(6, 100);
    chk_wr(4, 16'hB800, 8'h12);
    chk_wr(5, 16'hB801, 8'h34);
    chk("staw_adjacent", wc[5] - wc[4], 32'd1);

    // SLAW of 8001
    wait_wr(8, 100);
    chk_wr(6, 16'hB004, 8'h00);
    chk_wr(7, 16'hB005, 8'h02);
    chk("slaw_l", {31'h0, dut.l_q}, 32'd1);

    // 80 - 02 -> 7E, no borrow, overflow
    wait_wr(9, 100);
    chk_wr(8, 16'hB006, 8'h7E);
    chk("sub_l", {31'h0, dut.l_q}, 32'd1);
    chk("sub_v", {31'h0, dut.v_q}, 32'd1);
    chk("sub_n", {31'h0, dut.n_q}, 32'd0);

    // End write then HLT
    wait_wr(10, 100);
    chk_wr(9, 16'hF900, 8'h01);
    chk("hlt_fetch_addr", {16'h0, address}, 32'h8036);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("halt_addr", {16'h0, address}, 32'h8037);
      chk("halt_we", {31'h0, write_en}, 32'd0);
    end
    chk("halt_no_writes", wr_cnt, 32'd10);

    // Restart with a program whose word store gets cut by reset
    mem[16'hFD00] = 8'h71; mem[16'hFD01] = 8'h90; mem[16'hFD02] = 8'h00;
    prog = '{8'h90, 8'hAB, 8'hCD, 8'hB1, 8'hC0, 8'h00, 8'hA1, 8'hC1, 8'h00, 8'h00};
    foreach (prog[i]) mem[16'h9000 + i] = prog[i];
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("restart_addr", {16'h0, address}, 32'hFD00);
    wait_wr(11, 100);
    chk_wr(10, 16'hC000, 8'hAB);
    chk("staw2_we", {31'h0, write_en}, 32'd1);
    chk("staw2_addr", {16'h0, address}, 32'hC001);
    chk("staw2_dout", {24'h0, data_out}, 32'hCD);
    reset = 1'b1;
    #1;
    chk("abort_we", {31'h0, write_en}, 32'd0);
    chk("abort_addr", {16'h0, address}, 32'hFD00);
    chk("abort_dout", {24'h0, data_out}, 32'd0);
    @(negedge clock);
    chk("post_rst_we", {31'h0, write_en}, 32'd0);
    reset = 1'b0;
    #1;
    chk("refetch0", {16'h0, address}, 32'hFD00);
    @(negedge clock);
    chk("refetch1", {16'h0, address}, 32'hFD01);
    chk("abort_no_write", wr_cnt, 32'd11);
    chk("abort_mem", {24'h0, mem[16'hC001]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
